// File: rtl/output_sram_write_arbiter_pkg.sv
// Shared types and sizing for the bank-to-output-SRAM write path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package output_sram_write_arbiter_pkg;

    localparam int NUM_BANKS_DEF = 4;
    localparam int FV_SIZE       = 8;
    localparam int MAX_FV_NUM    = 8;
    localparam int MAX_NODE_ID   = 16;
    localparam int ROW_BEATS     = MAX_FV_NUM / 2;

    localparam int NODE_W = $clog2(MAX_NODE_ID);
    localparam int ADDR_W = $clog2(MAX_NODE_ID * ROW_BEATS);
    // Beat counter must be able to hold ROW_BEATS itself to detect overflow.
    localparam int BCNT_W = $clog2(ROW_BEATS + 1);

    // One bank's request pulse plus its 2-element-per-beat FV stream.
    typedef struct packed {
        logic                        req;
        logic                        Grant_valid;
        logic                        sos;
        logic                        eos;
        logic [NODE_W-1:0]           nodeid;
        logic [1:0][FV_SIZE-1:0]     data;
    } Bank_Req2Req_Output_SRAM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RECV  = 2'd2
    } arb_state_e;

    // Each node owns ROW_BEATS consecutive SRAM words.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [NODE_W-1:0] nodeid,
                                                   input logic [BCNT_W-1:0] beat);
        row_addr = ADDR_W'(nodeid) * ADDR_W'(ROW_BEATS) + ADDR_W'(beat);
    endfunction

endpackage

// File: rtl/output_sram_write_arbiter_rr_arbiter.sv
// Round-robin pick: first set bit of pending, searching upward from rr_ptr.
// Latency: purely combinational.
// Backpressure: none; valid is low when nothing is pending.
module output_sram_write_arbiter_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         pending,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         winner,
    output logic                 valid
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // Walk the ring starting at rr_ptr; the first pending slot wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!valid && pending[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_sram_write_arbiter.sv
// Queues bank FV requests, grants one bank at a time round-robin, writes its beats to SRAM.
// Latency: SRAM write and wr_done registered 1 cycle after the beat; >=1 idle cycle between FVs.
// Backpressure: banks stall by dropping Grant_valid; no timeout, requests are latched until granted.
module output_sram_write_arbiter
    import output_sram_write_arbiter_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  Bank_Req2Req_Output_SRAM [NUM_BANKS-1:0] bank_pkt,
    output logic [NUM_BANKS-1:0]                   req_grant,
    output logic                                   sram_wen,
    output logic [ADDR_W-1:0]                      sram_waddr,
    output logic [2*FV_SIZE-1:0]                   sram_wdata,
    output logic                                   wr_done,
    output logic [NODE_W-1:0]                      wr_done_nodeid,
    output logic                                   overflow_err,
    output logic                                   busy
);
    localparam int PW = $clog2(NUM_BANKS);

    arb_state_e               state, state_nxt;
    logic [NUM_BANKS-1:0]     pending;
    logic [NUM_BANKS-1:0]     req_vec;
    logic [NUM_BANKS-1:0]     unused_sos;
    logic [NUM_BANKS-1:0]     arb_winner;
    logic                     arb_valid;
    logic [PW-1:0]            arb_idx;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            win_idx;
    logic [NODE_W-1:0]        node_q;
    logic [BCNT_W-1:0]        beat_cnt;

    logic                     sel_vld;
    logic                     sel_eos;
    logic [NODE_W-1:0]        sel_node;
    logic [2*FV_SIZE-1:0]     sel_data;

    logic                     do_write;
    logic                     ovf_beat;
    logic                     last_beat;
    logic [ADDR_W-1:0]        wr_addr;
    logic [NUM_BANKS-1:0]     clr_mask;

    // Split the request pulses out of the bank packets; sos is informational only.
    always_comb begin
        req_vec    = '0;
        unused_sos = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            req_vec[i]    = bank_pkt[i].req;
            unused_sos[i] = bank_pkt[i].sos;
        end
    end

    // Only the granted bank's stream is observed.
    assign sel_vld  = bank_pkt[win_idx].Grant_valid;
    assign sel_eos  = bank_pkt[win_idx].eos;
    assign sel_node = bank_pkt[win_idx].nodeid;
    assign sel_data = {bank_pkt[win_idx].data[1], bank_pkt[win_idx].data[0]};

    output_sram_write_arbiter_rr_arbiter #(
        .N (NUM_BANKS)
    ) u_rr_arbiter (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (arb_winner),
        .valid   (arb_valid)
    );

    // One-hot winner to index for the granted-bank mux.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (arb_winner[i]) begin
                arb_idx = PW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-beat write decisions.
    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        ovf_beat  = 1'b0;
        last_beat = 1'b0;
        wr_addr   = '0;
        clr_mask  = '0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The bank answers the grant in the same cycle with its first beat.
                if (sel_vld) begin
                    do_write  = 1'b1;
                    last_beat = sel_eos;
                    wr_addr   = row_addr(sel_node, BCNT_W'(0));
                    clr_mask  = req_grant;
                    state_nxt = sel_eos ? ST_IDLE : ST_RECV;
                end else begin
                    // No answer: leave pending set so the bank is tried again.
                    state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (sel_vld) begin
                    ovf_beat  = (beat_cnt == BCNT_W'(ROW_BEATS));
                    do_write  = !ovf_beat;
                    last_beat = sel_eos;
                    wr_addr   = row_addr(node_q, beat_cnt);
                    if (sel_eos) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch: a new pulse in the grant cycle re-sets the bit (set wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | req_vec;
        end
    end

    // Grant decode, winner/node capture, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_grant <= '0;
            win_idx   <= '0;
            node_q    <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
        end else begin
            req_grant <= (state == ST_IDLE && arb_valid) ? arb_winner : '0;
            if (state == ST_IDLE && arb_valid) begin
                win_idx <= arb_idx;
            end
            if (state == ST_GRANT && sel_vld) begin
                node_q   <= sel_node;
                beat_cnt <= BCNT_W'(1);
            end else if (state == ST_RECV && do_write) begin
                beat_cnt <= beat_cnt + BCNT_W'(1);
            end
            if (last_beat) begin
                rr_ptr <= PW'((int'(win_idx) + 1) % NUM_BANKS);
            end
        end
    end

    // Registered SRAM write port, completion pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_wen       <= 1'b0;
            sram_waddr     <= '0;
            sram_wdata     <= '0;
            wr_done        <= 1'b0;
            wr_done_nodeid <= '0;
            overflow_err   <= 1'b0;
        end else begin
            sram_wen <= do_write;
            if (do_write) begin
                sram_waddr <= wr_addr;
                sram_wdata <= sel_data;
            end
            wr_done <= last_beat;
            if (last_beat) begin
                wr_done_nodeid <= (state == ST_GRANT) ? sel_node : node_q;
            end
            if (ovf_beat) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE) || (|pending);

endmodule

// File: tb/tb_output_sram_write_arbiter.sv
// Directed bench: table of request scenarios plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: bank models stall their stream on configured beats.
module tb_output_sram_write_arbiter;
    import output_sram_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Bank_Req2Req_Output_SRAM [3:0] bank_pkt;
    logic [3:0]          req_grant;
    logic                sram_wen;
    logic [ADDR_W-1:0]   sram_waddr;
    logic [15:0]         sram_wdata;
    logic                wr_done;
    logic [NODE_W-1:0]   wr_done_nodeid;
    logic                overflow_err;
    logic                busy;

    output_sram_write_arbiter #(.NUM_BANKS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .bank_pkt       (bank_pkt),
        .req_grant      (req_grant),
        .sram_wen       (sram_wen),
        .sram_waddr     (sram_waddr),
        .sram_wdata     (sram_wdata),
        .wr_done        (wr_done),
        .wr_done_nodeid (wr_done_nodeid),
        .overflow_err   (overflow_err),
        .busy           (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Bank model configuration, driven from the test.
    logic [3:0] req_vec = '0;
    int node_cfg [4];
    int nb_cfg [4];
    int stall_at = 0;
    int stall_len = 0;

    // Bank model streaming state.
    logic [3:0] act;
    int idx [4];
    int stall_rem [4];
    int beat_v [4];

    function automatic int elem(input int b, input int k, input int j);
        return b * 32 + 2 * k + j + 1;
    endfunction

    // Banks answer a grant combinationally with beat 0, then stream the rest.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            beat_v[i] = -1;
            if (req_grant[i]) beat_v[i] = 0;
            else if (act[i] && !(idx[i] == stall_at && stall_rem[i] > 0)) beat_v[i] = idx[i];
            bank_pkt[i] = '0;
            bank_pkt[i].req = req_vec[i];
            bank_pkt[i].nodeid = NODE_W'(node_cfg[i]);
            if (beat_v[i] >= 0) begin
                bank_pkt[i].Grant_valid = 1'b1;
                bank_pkt[i].sos = (beat_v[i] == 0);
                bank_pkt[i].eos = (beat_v[i] == nb_cfg[i] - 1);
                bank_pkt[i].data[0] = 8'(elem(i, beat_v[i], 0));
                bank_pkt[i].data[1] = 8'(elem(i, beat_v[i], 1));
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                act[i] <= 1'b0;
                idx[i] <= 0;
                stall_rem[i] <= 0;
            end else if (req_grant[i]) begin
                act[i] <= (nb_cfg[i] > 1);
                idx[i] <= 1;
                stall_rem[i] <= stall_len;
            end else if (act[i]) begin
                if (idx[i] == stall_at && stall_rem[i] > 0) begin
                    stall_rem[i] <= stall_rem[i] - 1;
                end else begin
                    idx[i] <= idx[i] + 1;
                    if (idx[i] == nb_cfg[i] - 1) act[i] <= 1'b0;
                end
            end
        end
    end

    // Observed traffic.
    logic [ADDR_W-1:0] wa_q [$];
    logic [15:0]       wd_q [$];
    logic [3:0]        dn_q [$];
    logic [3:0]        g_q  [$];

    always @(negedge clk) begin
        if (sram_wen) begin
            wa_q.push_back(sram_waddr);
            wd_q.push_back(sram_wdata);
        end
        if (wr_done) dn_q.push_back(wr_done_nodeid);
        if (req_grant != 4'b0) g_q.push_back(req_grant);
    end

    task automatic check(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act_v, exp_v);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        dn_q.delete();
        g_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        req_vec = m;
        @(negedge clk);
        req_vec = 4'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int c;
        c = 0;
        while (busy && c < lim) begin
            @(negedge clk);
            c++;
        end
        check({nm, " idle_timeout"}, 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    // Scenario record: request mask, node ids, beats per FV, stall, expected grant order.
    typedef struct packed {
        logic [3:0] mask;
        int n0; int n1; int n2; int n3;
        int nb; int sa; int sl;
        int no; int o0; int o1; int o2;
        logic ovf;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] m, input int n0, input int n1, input int n2,
                                input int n3, input int nb, input int sa, input int sl,
                                input int no, input int o0, input int o1, input int o2,
                                input logic ovf);
        vec_t v;
        v.mask = m; v.n0 = n0; v.n1 = n1; v.n2 = n2; v.n3 = n3;
        v.nb = nb; v.sa = sa; v.sl = sl;
        v.no = no; v.o0 = o0; v.o1 = o1; v.o2 = o2; v.ovf = ovf;
        return v;
    endfunction

    function automatic int ord(input vec_t v, input int k);
        case (k)
            0: return v.o0;
            1: return v.o1;
            default: return v.o2;
        endcase
    endfunction

    function automatic int nodeof(input vec_t v, input int b);
        case (b)
            0: return v.n0;
            1: return v.n1;
            2: return v.n2;
            default: return v.n3;
        endcase
    endfunction

    task automatic run_row(input int r, input vec_t v);
        logic [ADDR_W-1:0] ea [$];
        logic [15:0]       ed [$];
        logic [3:0]        en [$];
        int b, nd, nw;
        do_reset();
        node_cfg[0] = v.n0; node_cfg[1] = v.n1; node_cfg[2] = v.n2; node_cfg[3] = v.n3;
        for (int i = 0; i < 4; i++) nb_cfg[i] = v.nb;
        stall_at = v.sa;
        stall_len = v.sl;
        clear_q();
        pulse(v.mask);
        wait_idle($sformatf("row%0d", r), 400);
        check($sformatf("row%0d grant_count", r), 64'(g_q.size()), 64'(v.no));
        for (int k = 0; k < v.no; k++) begin
            b = ord(v, k);
            nd = nodeof(v, b);
            check($sformatf("row%0d grant%0d", r, k), (k < g_q.size()) ? 64'(g_q[k]) : 64'(0),
                  64'(1) << b);
            nw = (v.nb < 4) ? v.nb : 4;
            for (int j = 0; j < nw; j++) begin
                ea.push_back(ADDR_W'(nd * 4 + j));
                ed.push_back({8'(elem(b, j, 1)), 8'(elem(b, j, 0))});
            end
            en.push_back(4'(nd));
        end
        check($sformatf("row%0d write_count", r), 64'(wa_q.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            check($sformatf("row%0d waddr%0d", r, i), (i < wa_q.size()) ? 64'(wa_q[i]) : '1, 64'(ea[i]));
            check($sformatf("row%0d wdata%0d", r, i), (i < wd_q.size()) ? 64'(wd_q[i]) : '1, 64'(ed[i]));
        end
        check($sformatf("row%0d done_count", r), 64'(dn_q.size()), 64'(en.size()));
        for (int i = 0; i < en.size(); i++) begin
            check($sformatf("row%0d done_node%0d", r, i), (i < dn_q.size()) ? 64'(dn_q[i]) : '1, 64'(en[i]));
        end
        check($sformatf("row%0d overflow_err", r), 64'(overflow_err), 64'(v.ovf));
    endtask

    vec_t vecs [5];

    initial begin
        int c;
        for (int i = 0; i < 4; i++) begin
            node_cfg[i] = 0;
            nb_cfg[i] = 1;
        end
        //                mask     n0 n1 n2 n3 nb sa sl no o0 o1 o2 ovf
        vecs[0] = mk(4'b0001,  3, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1'b0); // single request
        vecs[1] = mk(4'b1101,  5, 0, 7, 9, 2, 0, 0, 3, 0, 2, 3, 1'b0); // contention
        vecs[2] = mk(4'b0100,  0, 0, 6, 0, 5, 0, 0, 1, 2, 0, 0, 1'b1); // overflow
        vecs[3] = mk(4'b0010,  0, 2, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1'b0); // single-beat FV
        vecs[4] = mk(4'b0001,  4, 0, 0, 0, 4, 2, 3, 1, 0, 0, 0, 1'b0); // 3-cycle stall

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({req_grant, sram_wen, sram_waddr, sram_wdata, wr_done,
                                     wr_done_nodeid, overflow_err, busy}), 64'(0));
        reset = 1'b0;

        for (int r = 0; r < 5; r++) run_row(r, vecs[r]);

        // Round-robin fairness: bank0 re-requests during its own service alongside bank1.
        do_reset();
        node_cfg[0] = 1; node_cfg[1] = 2;
        for (int i = 0; i < 4; i++) nb_cfg[i] = 2;
        stall_at = 0; stall_len = 0;
        clear_q();
        pulse(4'b0001);
        c = 0;
        while (g_q.size() == 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("rr first_grant_seen", 64'(g_q.size()), 64'(1));
        pulse(4'b0011);
        wait_idle("rr", 400);
        check("rr grant_count", 64'(g_q.size()), 64'(3));
        check("rr grant0", (g_q.size() > 0) ? 64'(g_q[0]) : 64'(0), 64'(4'b0001));
        check("rr grant1", (g_q.size() > 1) ? 64'(g_q[1]) : 64'(0), 64'(4'b0010));
        check("rr grant2", (g_q.size() > 2) ? 64'(g_q[2]) : 64'(0), 64'(4'b0001));
        check("rr done1", (dn_q.size() > 1) ? 64'(dn_q[1]) : '1, 64'(2));

        // Reset in the middle of a stream, with another request pending.
        do_reset();
        node_cfg[2] = 1; node_cfg[3] = 11; node_cfg[0] = 7;
        for (int i = 0; i < 4; i++) nb_cfg[i] = 4;
        clear_q();
        pulse(4'b0100);
        repeat (2) @(negedge clk);
        check("midrst in_stream_wen", 64'(sram_wen), 64'(1));
        pulse(4'b1000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst outputs", 64'({req_grant, sram_wen, sram_waddr, sram_wdata, wr_done,
                                      wr_done_nodeid, overflow_err, busy}), 64'(0));
        repeat (3) @(negedge clk);
        check("midrst pending_dropped", 64'(busy), 64'(0));
        clear_q();
        pulse(4'b0001);
        wait_idle("midrst", 400);
        check("midrst grant", (g_q.size() > 0) ? 64'(g_q[0]) : 64'(0), 64'(4'b0001));
        check("midrst write_count", 64'(wa_q.size()), 64'(4));
        check("midrst waddr0", (wa_q.size() > 0) ? 64'(wa_q[0]) : '1, 64'(28));
        check("midrst waddr3", (wa_q.size() > 3) ? 64'(wa_q[3]) : '1, 64'(31));
        check("midrst wdata3", (wd_q.size() > 3) ? 64'(wd_q[3]) : '1, 64'(16'h0807));
        check("midrst done_node", (dn_q.size() > 0) ? 64'(dn_q[0]) : '1, 64'(7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
